// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Arbitrates between two bus masters (requester 0 = CPU core, requester 1 =
// DMA / debug loader) for the single shared synchronous memory port. One
// transaction is in flight at a time. The winner's op/addr/wdata are latched
// at grant, one memory strobe is issued, the read latency is waited out, and
// a one-cycle ack (plus read data for reads) is returned to the owner.
//
// Optional feature (compile-time macro CPU_ARB_ROUND_ROBIN_EN):
//   defined   : ties are broken in favour of the requester that did not win
//               the most recent grant (first tie after reset goes to req0).
//   undefined : fixed priority, req0 always wins a tie (req1 may starve).
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset (rst = 0 resets)
//   req0/wr0/addr0/wdata0 requester 0 request, op (1 = write), address, data
//   ack0/rdata0          requester 0 completion pulse and read data
//   req1/wr1/addr1/wdata1 requester 1 request, op, address, data
//   ack1/rdata1          requester 1 completion pulse and read data
//   mem_en/mem_we        memory strobe (one cycle per transaction) and write
//   mem_addr/mem_wdata   memory address / write data (zero outside the strobe)
//   mem_rdata            memory read data, valid MEM_RD_LATENCY cycles after
//                        a read strobe
//   busy                 high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  wr0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ACK   = 3'd3
  } state_t;

  // Read wait counter preload: WAIT is entered one cycle after the strobe, so
  // the data is due after MEM_RD_LATENCY-1 further WAIT cycles.
  localparam logic [2:0] RD_CNT_INIT = 3'(MEM_RD_LATENCY - 1);

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  owner_q, owner_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  pick1;

`ifdef CPU_ARB_ROUND_ROBIN_EN
  logic                  last_q, last_d;

  // Tie goes to whoever did not win last; a lone request always wins.
  always_comb begin
    pick1 = 1'b0;
    if (req0 && req1) begin
      pick1 = ~last_q;
    end else begin
      pick1 = ~req0;
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it is asking.
  always_comb begin
    pick1 = ~req0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef CPU_ARB_ROUND_ROBIN_EN
    last_d   = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = pick1;
          wr_d    = pick1 ? wr1    : wr0;
          addr_d  = pick1 ? addr1  : addr0;
          wdata_d = pick1 ? wdata1 : wdata0;
          state_d = ISSUE;
`ifdef CPU_ARB_ROUND_ROBIN_EN
          last_d  = pick1;
`endif
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d = ACK;
        end else begin
          state_d = WAIT;
          cnt_d   = RD_CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          // Only the owner's read register is touched.
          if (owner_q) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      owner_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

`ifdef CPU_ARB_ROUND_ROBIN_EN
  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Outputs decode straight from the state register so they drop to zero
  // the instant reset is applied.
  always_comb begin
    mem_en    = (state_q == ISSUE);
    mem_we    = mem_en && wr_q;
    mem_addr  = mem_en ? addr_q  : '0;
    mem_wdata = mem_en ? wdata_q : '0;
    ack0      = (state_q == ACK) && !owner_q;
    ack1      = (state_q == ACK) &&  owner_q;
    busy      = (state_q != IDLE);
    rdata0    = rdata0_q;
    rdata1    = rdata1_q;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req   [2];
  logic          wr    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          ack0, ack1, mem_en, mem_we, busy;
  logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .wr0(wr[0]), .addr0(addr[0]), .wdata0(wdata[0]),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req[1]), .wr1(wr[1]), .addr1(addr[1]), .wdata1(wdata[1]),
    .ack1(ack1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Background contents of every location not yet written.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory responder: synchronous memory, read data LAT cycles after strobe.
  bit [7:0] mem     [0:65535];
  bit       mem_vld [0:65535];
  logic [7:0] pipe [LAT];

  function automatic logic [7:0] resp_read(input logic [15:0] a);
    return mem_vld[a] ? mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      mem_vld[mem_addr] <= 1'b1;
    end
    pipe[0] <= (mem_en && !mem_we) ? resp_read(mem_addr) : 8'h00;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  // Reference memory image and expected rdata registers.
  bit [7:0]   ref_mem [0:65535];
  bit         ref_vld [0:65535];
  logic [7:0] rdm [2];

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    return ref_vld[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [7:0] d);
    ref_mem[a] = d;
    ref_vld[a] = 1'b1;
  endtask

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ack0"},      32'(ack0),      0);
    chk({tag, ".ack1"},      32'(ack1),      0);
    chk({tag, ".rdata0"},    32'(rdata0),    0);
    chk({tag, ".rdata1"},    32'(rdata1),    0);
    chk({tag, ".mem_en"},    32'(mem_en),    0);
    chk({tag, ".mem_we"},    32'(mem_we),    0);
    chk({tag, ".mem_addr"},  32'(mem_addr),  0);
    chk({tag, ".mem_wdata"}, 32'(mem_wdata), 0);
    chk({tag, ".busy"},      32'(busy),      0);
  endtask

  typedef struct {
    logic        r0, w0; logic [15:0] a0; logic [7:0] d0;
    logic        r1, w1; logic [15:0] a1; logic [7:0] d1;
    logic        own, ewe; logic [15:0] eaddr; logic [7:0] ewd; logic [7:0] erd;
  } vec_t;

  vec_t tbl [8];
  vec_t v;
  int   nticks;
  int   n_ack;
  int   seq [$];
  int   exp_o;

  // Random-phase model state (transaction level).
  bit          pend [2];
  bit          m_act;
  int          m_iss, m_ack;
  bit          m_own, m_wr;
  logic [15:0] m_addr;
  logic [7:0]  m_wd, m_rd;
  logic        e_en, e_ack;
`ifdef CPU_ARB_ROUND_ROBIN_EN
  bit          m_last;
`endif

  initial begin
    tbl[0] = '{1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b1,16'h00FF,8'hA5, 1'b1,1'b1,16'h00FF,8'hA5,8'h00};
    tbl[1] = '{1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b1,16'h8000,8'h3C, 1'b1,1'b1,16'h8000,8'h3C,8'h00};
    tbl[2] = '{1'b1,1'b0,16'h8000,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,16'h8000,8'h00,8'h3C};
    tbl[3] = '{1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,16'h00FF,8'h00, 1'b1,1'b0,16'h00FF,8'h00,8'hA5};
    tbl[4] = '{1'b1,1'b1,16'h0100,8'h5A, 1'b1,1'b1,16'h0200,8'h66, 1'b0,1'b1,16'h0100,8'h5A,8'h00};
    tbl[5] = '{1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b1,16'h0200,8'h66, 1'b1,1'b1,16'h0200,8'h66,8'h00};
    tbl[6] = '{1'b1,1'b0,16'h0100,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,16'h0100,8'h00,8'h5A};
`ifdef CPU_ARB_ROUND_ROBIN_EN
    tbl[7] = '{1'b1,1'b0,16'h0200,8'h00, 1'b1,1'b0,16'h0100,8'h00, 1'b1,1'b0,16'h0100,8'h00,8'h5A};
`else
    tbl[7] = '{1'b1,1'b0,16'h0200,8'h00, 1'b1,1'b0,16'h0100,8'h00, 1'b0,1'b0,16'h0200,8'h00,8'h66};
`endif

    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    rdm[0] = 8'h00; rdm[1] = 8'h00;

    // ---- reset state
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    // ---- both requesters hold writes continuously
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0300; wdata[0] = 8'h11;
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 16'h0301; wdata[1] = 8'h22;
    seq.delete();
    for (int k = 0; k < 11; k++) begin
      tick();
      if (ack0) seq.push_back(0);
      if (ack1) seq.push_back(1);
      chk("tie.ack_exclusive", 32'(ack0 && ack1), 0);
    end
    chk("tie.n_acks", 32'(seq.size()), 4);
    for (int k = 0; k < 4; k++) begin
`ifdef CPU_ARB_ROUND_ROBIN_EN
      exp_o = k % 2;
`else
      exp_o = 0;
`endif
      chk("tie.grant_order", (k < seq.size()) ? 32'(seq[k]) : 32'd2, 32'(exp_o));
    end
`ifdef CPU_ARB_ROUND_ROBIN_EN
    req[0] = 1'b0; req[1] = 1'b0;
    tick(); tick();
`else
    req[0] = 1'b0;
    tick(); tick(); tick();
    chk("starve.ack1_after_req0_drop", 32'(ack1), 1);
    req[1] = 1'b0;
    tick();
`endif
    ref_write(16'h0300, 8'h11);
    ref_write(16'h0301, 8'h22);

    // ---- table of single transactions
    for (int i = 0; i < 8; i++) begin
      v = tbl[i];
      req[0] = v.r0; wr[0] = v.w0; addr[0] = v.a0; wdata[0] = v.d0;
      req[1] = v.r1; wr[1] = v.w1; addr[1] = v.a1; wdata[1] = v.d1;
      tick();
      chk("tbl.mem_en",    32'(mem_en),    1);
      chk("tbl.mem_we",    32'(mem_we),    32'(v.ewe));
      chk("tbl.mem_addr",  32'(mem_addr),  32'(v.eaddr));
      chk("tbl.mem_wdata", 32'(mem_wdata), 32'(v.ewd));
      chk("tbl.busy",      32'(busy),      1);
      req[0] = 1'b0; req[1] = 1'b0;
      wr[0] = ~v.w0; wr[1] = ~v.w1; addr[0] = ~v.a0; addr[1] = ~v.a1;
      wdata[0] = ~v.d0; wdata[1] = ~v.d1;
      if (v.ewe) ref_write(v.eaddr, v.ewd);
      nticks = v.ewe ? 1 : 1 + LAT;
      for (int k = 0; k < nticks; k++) begin
        tick();
        chk("tbl.mem_en_off",   32'(mem_en),   0);
        chk("tbl.mem_addr_off", 32'(mem_addr), 0);
        if (k < nticks - 1) begin
          chk("tbl.early_ack0", 32'(ack0), 0);
          chk("tbl.early_ack1", 32'(ack1), 0);
        end
      end
      if (!v.ewe) rdm[v.own] = v.erd;
      chk("tbl.ack0",   32'(ack0),   32'(!v.own));
      chk("tbl.ack1",   32'(ack1),   32'(v.own));
      chk("tbl.rdata0", 32'(rdata0), 32'(rdm[0]));
      chk("tbl.rdata1", 32'(rdata1), 32'(rdm[1]));
      tick();
      chk("tbl.idle_busy", 32'(busy), 0);
      chk("tbl.idle_ack",  32'(ack0 || ack1), 0);
    end

    // ---- inputs change after grant, req dropped during WAIT
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h0010; wdata[0] = 8'h00;
    tick();
    addr[0] = 16'h0020;
    #1;
    chk("latch.mem_en",   32'(mem_en),   1);
    chk("latch.mem_addr", 32'(mem_addr), 32'h0010);
    tick();
    req[0] = 1'b0;
    n_ack = 0;
    rdm[0] = ref_read(16'h0010);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ack0) n_ack++;
      if (k == 2) begin
        chk("drop.ack0_on_time", 32'(ack0),   1);
        chk("drop.rdata0",       32'(rdata0), 32'(rdm[0]));
      end
    end
    chk("drop.ack0_count", 32'(n_ack), 1);

    // ---- reset in the middle of a read WAIT
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h0040;
    tick();
    req[0] = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_mid_wait");
    rdm[0] = 8'h00; rdm[1] = 8'h00;
    tick(); tick();
    chk_all_zero("rst_held");
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rst.no_ack",  32'(ack0 || ack1), 0);
      chk("rst.no_busy", 32'(busy), 0);
    end
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h1234;
    tick();
    chk("post_rst.mem_addr", 32'(mem_addr), 32'h1234);
    req[0] = 1'b0;
    for (int k = 0; k < LAT + 1; k++) tick();
    chk("post_rst.ack0",   32'(ack0),   1);
    rdm[0] = ref_read(16'h1234);
    chk("post_rst.rdata0", 32'(rdata0), 32'(rdm[0]));

    // ---- randomized traffic against transaction model
    pend[0] = 1'b0; pend[1] = 1'b0;
    m_act = 1'b0; m_iss = 0; m_ack = 0; m_own = 1'b0; m_wr = 1'b0;
    m_addr = '0; m_wd = '0; m_rd = '0;
`ifdef CPU_ARB_ROUND_ROBIN_EN
    m_last = 1'b0;
`endif
    for (int t = 0; t < 1500; t++) begin
      tick();
      if (m_act && cyc == m_iss) begin
        if (m_wr) ref_write(m_addr, m_wd);
        else      m_rd = ref_read(m_addr);
      end
      e_en  = m_act && (cyc == m_iss);
      e_ack = m_act && (cyc == m_ack);
      if (e_ack && !m_wr) rdm[m_own] = m_rd;
      chk("rnd.busy",      32'(busy),      32'(m_act));
      chk("rnd.mem_en",    32'(mem_en),    32'(e_en));
      chk("rnd.mem_we",    32'(mem_we),    32'(e_en && m_wr));
      chk("rnd.mem_addr",  32'(mem_addr),  e_en ? 32'(m_addr) : 32'd0);
      chk("rnd.mem_wdata", 32'(mem_wdata), e_en ? 32'(m_wd)   : 32'd0);
      chk("rnd.ack0",      32'(ack0),      32'(e_ack && !m_own));
      chk("rnd.ack1",      32'(ack1),      32'(e_ack &&  m_own));
      chk("rnd.rdata0",    32'(rdata0),    32'(rdm[0]));
      chk("rnd.rdata1",    32'(rdata1),    32'(rdm[1]));

      for (int k = 0; k < 2; k++) begin
        if (e_ack && (32'(m_own) == k)) pend[k] = 1'b0;
        if (!pend[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[k]  = 1'b1;
            req[k]   = 1'b1;
            wr[k]    = 1'($urandom_range(0, 1));
            addr[k]  = 16'($urandom_range(0, 31));
            wdata[k] = 8'($urandom);
          end else begin
            req[k] = 1'b0;
          end
        end else if (m_act && (32'(m_own) == k)) begin
          if ($urandom_range(0, 3) == 0) req[k] = 1'b0;
          wr[k]    = 1'($urandom_range(0, 1));
          addr[k]  = 16'($urandom);
          wdata[k] = 8'($urandom);
        end
      end

      if (m_act && cyc == m_ack) begin
        m_act = 1'b0;
      end else if (!m_act && (req[0] || req[1])) begin
`ifdef CPU_ARB_ROUND_ROBIN_EN
        m_own  = (req[0] && req[1]) ? !m_last : !req[0];
        m_last = m_own;
`else
        m_own  = !req[0];
`endif
        m_wr   = wr[m_own];
        m_addr = addr[m_own];
        m_wd   = wdata[m_own];
        m_iss  = cyc + 1;
        m_ack  = cyc + 2 + (m_wr ? 0 : LAT);
        m_act  = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
